// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one data-memory port between data and fetch requesters
// Reads hold the address for READ_LATENCY cycles; the owner gets a single-cycle rvalid.
module mem_port_arbiter #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          READ_LATENCY = 1,
  parameter logic [1:0]  FETCH_TYPE   = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_we,
  input  logic [1:0]            d_type,
  input  logic                  d_sign_ext,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [1:0]            mem_type,
  output logic                  mem_sign_ext,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  last_i_q, last_i_d;
  logic                  owner_i_q, owner_i_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [1:0]            hold_type_q, hold_type_d;
  logic                  hold_sext_q, hold_sext_d;
  logic                  d_win, i_win;

  // Data wins a tie unless it was the last port granted.
  assign d_win = d_valid && (!i_valid || last_i_q);
  assign i_win = i_valid && !d_win;

  always_comb begin
    state_d      = state_q;
    last_i_d     = last_i_q;
    owner_i_d    = owner_i_q;
    cnt_d        = cnt_q;
    hold_addr_d  = hold_addr_q;
    hold_type_d  = hold_type_q;
    hold_sext_d  = hold_sext_q;
    d_ready      = 1'b0;
    i_ready      = 1'b0;
    d_rvalid     = 1'b0;
    i_rvalid     = 1'b0;
    d_rdata      = '0;
    i_rdata      = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_type     = 2'b00;
    mem_sign_ext = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (d_win) begin
            d_ready      = 1'b1;
            mem_en       = 1'b1;
            mem_we       = d_we;
            mem_type     = d_type;
            mem_sign_ext = d_sign_ext;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
            last_i_d     = 1'b0;
            if (!d_we) begin
              owner_i_d   = 1'b0;
              cnt_d       = CNT_INIT;
              state_d     = WAIT;
              hold_addr_d = d_addr;
              hold_type_d = d_type;
              hold_sext_d = d_sign_ext;
            end
          end else if (i_win) begin
            i_ready     = 1'b1;
            mem_en      = 1'b1;
            mem_type    = FETCH_TYPE;
            mem_addr    = i_addr;
            last_i_d    = 1'b1;
            owner_i_d   = 1'b1;
            cnt_d       = CNT_INIT;
            state_d     = WAIT;
            hold_addr_d = i_addr;
            hold_type_d = FETCH_TYPE;
            hold_sext_d = 1'b0;
          end
        end
        WAIT: begin
          mem_addr     = hold_addr_q;
          mem_type     = hold_type_q;
          mem_sign_ext = hold_sext_q;
          if (cnt_q == 2'd0) begin
            state_d = IDLE;
            if (owner_i_q) begin
              i_rvalid = 1'b1;
              i_rdata  = mem_rdata;
            end else begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b1;
      owner_i_q   <= 1'b0;
      cnt_q       <= 2'd0;
      hold_addr_q <= '0;
      hold_type_q <= 2'b00;
      hold_sext_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      owner_i_q   <= owner_i_d;
      cnt_q       <= cnt_d;
      hold_addr_q <= hold_addr_d;
      hold_type_q <= hold_type_d;
      hold_sext_q <= hold_sext_d;
    end
  end

endmodule
